// File: rtl/udp_line_scheduler.sv
// Frame-level UDP line sequencer: one trig per line packet, paced by the UDP engine's busy flag.
// Define UDP_LINE_SCHED_DUAL_EN to interleave two cameras per row (2*V_ACT packets per frame).
module udp_line_scheduler #(
  parameter int V_ACT      = 720,
  parameter int GAP_CYCLES = 125,
  parameter int TIMEOUT    = 125_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       connected,
  input  logic       lb_ready,
  input  logic       udp_busy,
  input  logic       line_err,
  output logic       trig,
  output logic       cam_id,
  output logic [9:0] row,
  output logic       busy,
  output logic       frame_done,
  output logic       abort,
  output logic [1:0] abort_code
);

  localparam int          GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [9:0]  LAST_ROW = 10'(V_ACT - 1);
  localparam logic [16:0] WDOG_LIM = 17'(TIMEOUT);
`ifdef UDP_LINE_SCHED_DUAL_EN
  localparam logic        LAST_CAM = 1'b1;
`else
  localparam logic        LAST_CAM = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         row_q, row_d;
  logic               cam_q, cam_d;
  logic [16:0]        wdog_q, wdog_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               trig_q, busy_q;
  logic               fdone_q, fdone_d;
  logic               abort_q, abort_d;
  logic [1:0]         code_q, code_d;
  logic               last_pkt;
  logic               in_wait;
  logic [16:0]        wdog_inc;

  assign last_pkt = (row_q == LAST_ROW) && (cam_q == LAST_CAM);
  assign in_wait  = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
  assign wdog_inc = (wdog_q == '1) ? wdog_q : wdog_q + 17'd1;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cam_d   = cam_q;
    wdog_d  = '0;
    gap_d   = gap_q;
    fdone_d = 1'b0;
    abort_d = 1'b0;
    code_d  = code_q;

    case (state_q)
      S_IDLE: begin
        // The frame_done cycle already shows IDLE but must not accept a new start.
        if (start && connected && !fdone_q) begin
          state_d = S_ARM;
          row_d   = '0;
          cam_d   = 1'b0;
        end
      end
      S_ARM: begin
        if (lb_ready) state_d = S_FIRE;
      end
      S_FIRE: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (udp_busy) state_d = S_WAIT_DONE;
        else          wdog_d  = wdog_inc;
      end
      S_WAIT_DONE: begin
        if (!udp_busy) begin
          state_d = S_GAP;
          gap_d   = GAP_W'(GAP_CYCLES);
        end else begin
          wdog_d  = wdog_inc;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          if (last_pkt) begin
            fdone_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ARM;
            if (cam_q != LAST_CAM) begin
              cam_d = 1'b1;
            end else begin
              cam_d = 1'b0;
              row_d = row_q + 10'd1;
            end
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any normal transition and freezes the indices.
    if (state_q != S_IDLE) begin
      if (line_err || !connected || (in_wait && (wdog_q >= WDOG_LIM))) begin
        abort_d = 1'b1;
        state_d = S_IDLE;
        row_d   = row_q;
        cam_d   = cam_q;
        fdone_d = 1'b0;
        if (line_err)        code_d = 2'd1;
        else if (!connected) code_d = 2'd2;
        else                 code_d = 2'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cam_q   <= 1'b0;
      wdog_q  <= '0;
      gap_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      abort_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cam_q   <= cam_d;
      wdog_q  <= wdog_d;
      gap_q   <= gap_d;
      trig_q  <= (state_d == S_FIRE);
      busy_q  <= (state_d != S_IDLE);
      fdone_q <= fdone_d;
      abort_q <= abort_d;
      code_q  <= code_d;
    end
  end

  assign trig       = trig_q;
  assign cam_id     = cam_q;
  assign row        = row_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign abort      = abort_q;
  assign abort_code = code_q;

endmodule

// File: tb/tb_udp_line_scheduler.sv
// Bench for udp_line_scheduler: abort vector table, directed corner sequences and randomized frames
// checked against packet-order and timing rules derived from the frame description.
`timescale 1ns/1ps
module tb_udp_line_scheduler;

  localparam int V_ACT = 4;
  localparam int GAP   = 3;
  localparam int TMO   = 50;
`ifdef UDP_LINE_SCHED_DUAL_EN
  localparam int NCAM = 2;
`else
  localparam int NCAM = 1;
`endif
  localparam int NPKT = V_ACT * NCAM;

  logic       clk;
  logic       rst, start, connected, lb_ready, udp_busy, line_err;
  logic       trig, cam_id, busy, frame_done, abort;
  logic [9:0] row;
  logic [1:0] abort_code;

  udp_line_scheduler #(.V_ACT(V_ACT), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .connected(connected), .lb_ready(lb_ready),
    .udp_busy(udp_busy), .line_err(line_err), .trig(trig), .cam_id(cam_id), .row(row),
    .busy(busy), .frame_done(frame_done), .abort(abort), .abort_code(abort_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // UDP engine model and event log
  bit   udp_en, rand_lb, prev_ub;
  logic prev_lb;
  int   udp_lat, udp_len, ub_from, ub_to;
  int   trig_cyc[$], trig_row[$], trig_cam[$], fall_cyc[$];
  int   fd_cnt, fd_cyc, ab_cnt, ab_cyc, ab_code, lb_miss;

  typedef struct {
    int         phase;   // 0 ARM, 1 WAIT_BUSY, 2 WAIT_DONE, 3 GAP
    int         off;
    bit         lerr;
    bit         cdrop;
    logic [1:0] code;
  } ab_vec_t;
  ab_vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    prev_lb = lb_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (udp_en && trig) begin
      ub_from = cyc + udp_lat;
      ub_to   = ub_from + udp_len;
    end
    prev_ub  = udp_busy;
    udp_busy = udp_en && (cyc >= ub_from) && (cyc < ub_to);
    if (prev_ub && !udp_busy) fall_cyc.push_back(cyc);
    if (trig) begin
      trig_cyc.push_back(cyc);
      trig_row.push_back(int'(row));
      trig_cam.push_back(int'(cam_id));
      if (!prev_lb) lb_miss++;
    end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (abort) begin ab_cnt++; ab_cyc = cyc; ab_code = int'(abort_code); end
    if (rand_lb) lb_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_log();
    trig_cyc.delete(); trig_row.delete(); trig_cam.delete(); fall_cyc.delete();
    fd_cnt = 0; ab_cnt = 0; lb_miss = 0; ub_from = 0; ub_to = 0;
    udp_busy = 1'b0; line_err = 1'b0; connected = 1'b1;
  endtask

  task automatic wait_trig();
    int i = 0;
    tick();
    while (!trig && i < 300) begin tick(); i++; end
    check("trig_seen", int'(trig), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input int lat, input int len);
    clear_log();
    udp_en = 1'b1; udp_lat = lat; udp_len = len; rand_lb = rnd;
    if (!rnd) lb_ready = 1'b1;
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    for (int i = 0; i < 4000 && fd_cnt == 0 && ab_cnt == 0; i++) tick();
    rand_lb = 1'b0;
    check("frame_done_count", fd_cnt, 1);
    check("frame_abort_count", ab_cnt, 0);
    check("trig_count", trig_cyc.size(), NPKT);
    check("trig_without_lb_ready", lb_miss, 0);
    for (int p = 0; p < trig_cyc.size() && p < NPKT; p++) begin
      check("pkt_row", trig_row[p], p / NCAM);
      check("pkt_cam", trig_cam[p], p % NCAM);
      if (p > 0 && (p - 1) < fall_cyc.size()) begin
        if (rnd) check("trig_spacing_min", int'(trig_cyc[p] >= fall_cyc[p-1] + GAP + 3), 1);
        else     check("trig_spacing", trig_cyc[p], fall_cyc[p-1] + GAP + 3);
      end
    end
    if (fall_cyc.size() >= NPKT) check("frame_done_time", fd_cyc, fall_cyc[NPKT-1] + GAP + 2);
    else                         check("busy_fall_count", fall_cyc.size(), NPKT);
  endtask

  initial begin
    int t0, ntrig;
    tbl[0] = '{0, 5, 1'b1, 1'b0, 2'd1};
    tbl[1] = '{0, 5, 1'b0, 1'b1, 2'd2};
    tbl[2] = '{0, 5, 1'b1, 1'b1, 2'd1};
    tbl[3] = '{1, 3, 1'b1, 1'b0, 2'd1};
    tbl[4] = '{1, 3, 1'b0, 1'b1, 2'd2};
    tbl[5] = '{2, 3, 1'b1, 1'b1, 2'd1};
    tbl[6] = '{2, 3, 1'b0, 1'b1, 2'd2};
    tbl[7] = '{3, 5, 1'b1, 1'b0, 2'd1};
    tbl[8] = '{3, 5, 1'b0, 1'b1, 2'd2};

    rst = 1'b1; start = 1'b0; lb_ready = 1'b0; udp_en = 1'b0; rand_lb = 1'b0;
    udp_lat = 1; udp_len = 1;
    clear_log();
    repeat (3) tick();
    check("rst_trig", int'(trig), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_abort", int'(abort), 0);
    check("rst_cam_id", int'(cam_id), 0);
    check("rst_row", int'(row), 0);
    check("rst_abort_code", int'(abort_code), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Directed full frame, then start on the frame_done cycle is ignored
    run_frame(1'b0, 1, 10);
    start = 1'b1; tick();
    check("start_on_frame_done_ignored", int'(busy), 0);
    tick(); start = 1'b0;
    check("start_after_frame_done", int'(busy), 1);
    line_err = 1'b1; tick(); line_err = 1'b0;
    check("cleanup_abort", int'(abort), 1);
    check("cleanup_code", int'(abort_code), 1);
    tick();

    // Abort vector table
    for (int v = 0; v < 9; v++) begin
      clear_log();
      udp_en = 1'b1;
      case (tbl[v].phase)
        1:       begin udp_lat = 20; udp_len = 5;  end
        2:       begin udp_lat = 1;  udp_len = 20; end
        default: begin udp_lat = 1;  udp_len = 2;  end
      endcase
      lb_ready = (tbl[v].phase != 0);
      pulse_start();
      if (tbl[v].phase != 0) wait_trig();
      repeat (tbl[v].off) tick();
      check("pre_abort_busy", int'(busy), 1);
      line_err = tbl[v].lerr; connected = !tbl[v].cdrop;
      tick();
      check("abort_pulse", int'(abort), 1);
      check("abort_code", int'(abort_code), int'(tbl[v].code));
      check("abort_busy", int'(busy), 0);
      line_err = 1'b0; connected = 1'b1;
      tick();
      check("abort_one_cycle", int'(abort), 0);
      check("abort_code_hold", int'(abort_code), int'(tbl[v].code));
      lb_ready = 1'b0;
      tick();
    end

    // Stalled engine: udp_busy never rises
    clear_log();
    udp_en = 1'b0; lb_ready = 1'b1;
    pulse_start();
    wait_trig();
    t0 = cyc;
    for (int i = 0; i < 200 && ab_cnt == 0; i++) tick();
    check("stall_abort_latency", cyc - t0, 52);
    check("stall_abort_code", ab_code, 3);
    check("stall_busy", int'(busy), 0);
    lb_ready = 1'b0;
    tick();

    // Link loss in the third packet's WAIT_DONE
    clear_log();
    udp_en = 1'b1; udp_lat = 1; udp_len = 10; lb_ready = 1'b1;
    pulse_start();
    repeat (3) wait_trig();
    repeat (4) tick();
    connected = 1'b0;
    tick();
    check("link_abort", int'(abort), 1);
    check("link_abort_code", int'(abort_code), 2);
    ntrig = trig_cyc.size();
    repeat (40) tick();
    check("link_no_more_trig", trig_cyc.size(), ntrig);
    pulse_start();
    repeat (3) tick();
    check("start_disconnected_busy", int'(busy), 0);
    check("start_disconnected_abort", ab_cnt, 1);
    connected = 1'b1;
    tick();

    // Late line buffer: 200 cycles in ARM without timeout
    clear_log();
    udp_en = 1'b1; udp_lat = 1; udp_len = 10; lb_ready = 1'b0;
    pulse_start();
    repeat (200) tick();
    check("late_no_abort", ab_cnt, 0);
    check("late_no_trig", trig_cyc.size(), 0);
    check("late_busy", int'(busy), 1);
    lb_ready = 1'b1;
    tick();
    check("late_trig", int'(trig), 1);
    repeat (3) tick();
    connected = 1'b0;
    tick();
    check("late_link_abort_code", int'(abort_code), 2);
    connected = 1'b1; lb_ready = 1'b0;
    tick();

    // Randomized frames
    for (int k = 0; k < 3; k++) begin
      run_frame(1'b1, $urandom_range(1, 6), $urandom_range(1, 12));
      lb_ready = 1'b0;
      repeat ($urandom_range(1, 5)) tick();
    end

    // Asynchronous reset in the middle of the fourth packet
    clear_log();
    udp_en = 1'b1; udp_lat = 1; udp_len = 10; lb_ready = 1'b1;
    pulse_start();
    repeat (4) wait_trig();
    repeat (2) tick();
    check("pre_rst_row", int'(row), 3 / NCAM);
    check("pre_rst_cam", int'(cam_id), 3 % NCAM);
    check("pre_rst_code", int'(abort_code), 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_trig", int'(trig), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_frame_done", int'(frame_done), 0);
    check("mid_rst_abort", int'(abort), 0);
    check("mid_rst_cam_id", int'(cam_id), 0);
    check("mid_rst_row", int'(row), 0);
    check("mid_rst_abort_code", int'(abort_code), 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/udp_line_scheduler.md
# udp_line_scheduler

Sequences one camera frame out over UDP, one line per packet. It drives the shared trigger to the line swap buffer and the UDP packet engine, and walks row and camera indices through a whole frame. It paces packets using the UDP engine's busy indication and aborts on line-buffer errors, link loss or a stalled engine. It sits in the `rgmii_clk` domain and replaces the free-running send trigger.

## Interface
- `V_ACT`, 720: rows per frame; the last row index sent is `V_ACT-1`.
- `GAP_CYCLES`, 125: idle cycles inserted after each packet completes. 0 is legal and means no gap.
- `TIMEOUT`, 125_000: maximum cycles allowed in WAIT_BUSY or WAIT_DONE before abort.

- `clk`  in  1: `rgmii_clk`. Every signal on this block is synchronous to it.
- `rst`  in  1: asynchronous reset, active-high.
- `start`  in  1: single-cycle request to send one frame.
- `connected`  in  1: link/ARP resolved, from the UDP engine.
- `lb_ready`  in  1: line buffer holds a complete line for the current `cam_id`/`row`.
- `udp_busy`  in  1: UDP engine is transmitting a packet.
- `line_err`  in  1: line buffer error.
- `trig`  out  1: one-cycle pulse that launches a packet. It drives the line buffer and the UDP engine together.
- `cam_id`  out  1: camera index of the current packet.
- `row`  out  10: row index of the current packet.
- `busy`  out  1: high whenever the state is not IDLE.
- `frame_done`  out  1: one-cycle pulse after the last packet of a frame completes.
- `abort`  out  1: one-cycle pulse when a frame is abandoned.
- `abort_code`  out  2: reason for the abort; values are listed under Operation.

## Operation
- States: IDLE, ARM, FIRE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - On `start` with `connected`=1: go to ARM and set `row`=0, `cam_id`=0.
  - `start` while `connected`=0 is dropped with no response.
- ARM: wait for `lb_ready`=1, then go to FIRE. There is no timeout in ARM.
- FIRE: `trig`=1 for exactly this cycle; go to WAIT_BUSY and clear the watchdog.
- WAIT_BUSY: on `udp_busy`=1, go to WAIT_DONE and clear the watchdog.
- WAIT_DONE: on `udp_busy`=0, go to GAP and load the gap counter with `GAP_CYCLES`.
- GAP: count down to 0, then advance to the next packet.
  - If this was the last packet of the frame, pulse `frame_done` and go to IDLE.
  - Otherwise update the indices and go to ARM.
  - With `GAP_CYCLES`=0, GAP lasts exactly one cycle.
- Advance order when dual-camera is enabled:
  - `cam_id` 0→1 with the same row.
  - `cam_id` 1→0 with `row`+1.
  - The frame ends after (`row`=`V_ACT-1`, `cam_id`=1).
- Abort triggers, checked in every non-IDLE state:
  - `line_err`=1 gives code 1.
  - `connected`=0 gives code 2.
  - Watchdog reaching `TIMEOUT` in WAIT_BUSY or WAIT_DONE gives code 3.
- Abort response:
  - `abort` pulses for one cycle with `abort_code` valid in the same cycle.
  - `abort_code` holds until the next abort or reset.
  - Next state is IDLE.
- Abort priority when several triggers occur together: code 1, then 2, then 3.
- If an abort and a normal transition occur in the same cycle, the abort wins.
- Any `start` outside IDLE is ignored. This includes the `frame_done` cycle; a new frame can be accepted from the following cycle.
- Watchdog: a 17-bit counter, saturating, compared with `>= TIMEOUT`.
- `row` is held in 10 bits. It never exceeds `V_ACT-1` and never wraps.

## Timing
- Reset values: state IDLE; `trig`, `busy`, `frame_done`, `abort` all 0; `cam_id`=0, `row`=0, `abort_code`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `start` at cycle N gives `busy`=1 at N+1.
- `lb_ready` sampled high in ARM at cycle M gives `trig`=1 at M+1.
- `cam_id` and `row` change only on the ARM entry cycle. They are stable from ARM through the end of GAP.
- `udp_busy` falling at cycle K in WAIT_DONE:
  - The next `trig` is no earlier than K+`GAP_CYCLES`+3.
  - `frame_done` appears at K+`GAP_CYCLES`+2.
- `rst` asserted mid-frame clears everything immediately. `trig` never glitches high on reset.

## Configuration
- Macro: `UDP_LINE_SCHED_DUAL_EN`.
- Defined: packets alternate between cameras per row, giving 2×`V_ACT` packets per frame.
- Undefined:
  - `cam_id` is tied to 0 and each row advances after a single packet, giving `V_ACT` packets per frame.
  - The frame ends after `row`=`V_ACT-1`.

## Test plan
All scenarios use `V_ACT`=4, `GAP_CYCLES`=3, `TIMEOUT`=50 and dual mode, unless stated otherwise.
- Full frame: `start`, with `lb_ready` held 1 and a UDP model busy for 10 cycles after each `trig` → 8 `trig` pulses with (`row`,`cam_id`) = (0,0),(0,1),(1,0)…(3,1). Then exactly one `frame_done` and no `abort`.
- Stalled engine: `udp_busy` never rises after the first `trig` → `abort` with code 3 exactly 51 cycles after the cycle following `trig`. Then `busy`=0.
- Link loss: `connected` drops during the third packet's WAIT_DONE → `abort` with code 2 one cycle later, and no further `trig`. A `start` with `connected`=0 afterwards gets no response.
- Error priority: `line_err` and `connected`=0 in the same cycle → `abort_code`=1.
- Late buffer: `lb_ready` held 0 for 200 cycles in ARM → no abort. `trig` is one cycle after `lb_ready` rises.
- Single-camera build (macro undefined): full frame → 4 `trig` pulses, `cam_id` always 0. Also `rst` pulsed mid-frame → all outputs at reset values in the same cycle.
